// File: rtl/lu_arbiter_pkg.sv
// Shared definitions for the logic-unit arbiter: default widths, opcode
// encodings and the response-register state type.
package lu_arbiter_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int OPW_DEF   = 3;

    localparam logic [OPW_DEF-1:0] OP_AND  = 3'b000;
    localparam logic [OPW_DEF-1:0] OP_NAND = 3'b001;
    localparam logic [OPW_DEF-1:0] OP_OR   = 3'b010;
    localparam logic [OPW_DEF-1:0] OP_NOR  = 3'b011;
    localparam logic [OPW_DEF-1:0] OP_XOR  = 3'b100;
    localparam logic [OPW_DEF-1:0] OP_XNOR = 3'b101;
    localparam logic [OPW_DEF-1:0] OP_PASS = 3'b110;
    localparam logic [OPW_DEF-1:0] OP_NOT  = 3'b111;

    // EMPTY: no result held; FULL: result register holds a valid response
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_t;

    // Round-robin pick between two requesters; on contention the one that
    // was not granted last time wins.
    function automatic logic pick_grant(input logic v0, input logic v1,
                                        input logic last);
        logic idx;
        idx = 1'b0;
        if (v0 && v1) begin
            idx = ~last;
        end else if (v1) begin
            idx = 1'b1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/lu_arbiter_lu.sv
// Purely combinational bitwise logic unit shared by both requesters.
module lu_arbiter_lu
    import lu_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
) (
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] arg1,
    input  logic [WIDTH-1:0] arg2,
    output logic [WIDTH-1:0] result
);

    // Decode the opcode into one of eight bitwise functions
    always_comb begin
        result = '0;
        case (opcode)
            OP_AND:  result = arg1 & arg2;
            OP_NAND: result = ~(arg1 & arg2);
            OP_OR:   result = arg1 | arg2;
            OP_NOR:  result = ~(arg1 | arg2);
            OP_XOR:  result = arg1 ^ arg2;
            OP_XNOR: result = ~(arg1 ^ arg2);
            OP_PASS: result = arg1;
            OP_NOT:  result = ~arg1;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/lu_arbiter.sv
// Two-requester arbiter in front of a single logic unit. The granted
// operation is evaluated combinationally and captured into a one-deep
// response register that supports full throughput under a ready/valid
// handshake.
module lu_arbiter
    import lu_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_opcode,
    input  logic [WIDTH-1:0] req0_arg1,
    input  logic [WIDTH-1:0] req0_arg2,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_opcode,
    input  logic [WIDTH-1:0] req1_arg1,
    input  logic [WIDTH-1:0] req1_arg2,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,

    output logic [15:0]      op_count
);

    rsp_state_t       state;
    rsp_state_t       state_next;
    logic             accept_en;
    logic             grant_valid;
    logic             grant_idx;
    logic             last_grant;
    logic             xfer;
    logic [OPW-1:0]   mux_opcode;
    logic [WIDTH-1:0] mux_arg1;
    logic [WIDTH-1:0] mux_arg2;
    logic [WIDTH-1:0] lu_result;

    assign rsp_valid = (state == ST_FULL);

    // A new operation can enter when the register is empty or being drained
    assign accept_en = !rsp_valid || rsp_ready;

    // Choose which requester owns the logic unit this cycle
    always_comb begin
        grant_valid = req0_valid || req1_valid;
        grant_idx   = pick_grant(req0_valid, req1_valid, last_grant);
    end

    // Readies are held low during reset so nothing is consumed then
    assign req0_ready = !rst && accept_en && grant_valid && (grant_idx == 1'b0);
    assign req1_ready = !rst && accept_en && grant_valid && (grant_idx == 1'b1);

    assign xfer = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // Steer the granted requester's operands into the shared logic unit
    always_comb begin
        mux_opcode = req0_opcode;
        mux_arg1   = req0_arg1;
        mux_arg2   = req0_arg2;
        if (grant_idx) begin
            mux_opcode = req1_opcode;
            mux_arg1   = req1_arg1;
            mux_arg2   = req1_arg2;
        end
    end

    lu_arbiter_lu #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_lu (
        .opcode (mux_opcode),
        .arg1   (mux_arg1),
        .arg2   (mux_arg2),
        .result (lu_result)
    );

    // Response-register occupancy state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Fill on transfer; empty only when drained without a refill
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (xfer) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (rsp_ready && !xfer) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Capture the result and its owner; held steady until the next transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result <= '0;
            rsp_id     <= 1'b0;
        end else if (xfer) begin
            rsp_result <= lu_result;
            rsp_id     <= grant_idx;
        end
    end

    // Remember the last winner; reset to 1 so requester 0 wins first contention
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (xfer) begin
            last_grant <= grant_idx;
        end
    end

    // Count accepted operations, wrapping naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= 16'd0;
        end else if (xfer) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule
